if_fetch: RTL and testbench
===========================

// Module: if_fetch
// PURPOSE
//   Instruction-fetch front end (IF1+IF2) and producer of if22id_bus for the ID stage.
//   IF1 computes next PC and issues a 1-cycle-latency synchronous inst SRAM read.
//   IF2 pairs the returned word with its PC and presents {pc,inst} (zero = bubble).
//   Obeys the shared stall vector and branch redirect (br_e/br_addr) from EX.
// PARAMETERS
//   RESET_PC   32'h8000_0000  address of first fetched instruction after reset
//   STALL_WD   6              width of stall bus (`StallBus)
// PORTS
//   clk              in   1         clock, all state on rising edge
//   rst_n            in   1         reset, asynchronous assert, active-low
//   stall            in   STALL_WD  [0]=hold PC/IF1, [1]=hold IF2; others unused here
//   br_e             in   1         branch/jump redirect pulse from EX
//   br_addr          in   32        redirect target; bits[1:0] ignored (forced 00)
//   inst_sram_en     out  1         SRAM read enable
//   inst_sram_addr   out  32        SRAM read byte address, word aligned
//   inst_sram_rdata  in   32        SRAM data, valid the cycle after en&edge
//   if22id_bus       out  64        {pc[31:0], inst[31:0]}; all-zero = bubble
// BEHAVIOUR
//   State: pc1[31:0], v1, buf_inst[31:0], buf_v.
//   Reset (async, rst_n=0): pc1=RESET_PC-4, v1=0, buf_v=0, buf_inst=0;
//     outputs: if22id_bus=0, inst_sram_en=0 while rst_n=0.
//   next_pc = br_e ? {br_addr[31:2],2'b00} : pc1+4 (32-bit wrap, FFFF_FFFC -> 0).
//   inst_sram_en = rst_n & (br_e | (!stall[0] & !stall[1])); inst_sram_addr = next_pc.
//   Per edge, priority order:
//     1 br_e: pc1<=next_pc, v1<=1, buf_v<=0 (in-flight word and IF2 content dropped).
//     2 stall[1]: pc1,v1 hold; if v1&!buf_v: buf_inst<=rdata, buf_v<=1.
//     3 stall[0]&!stall[1]: pc1 holds, v1<=0 (IF2 drains, bubble to ID), buf_v<=0.
//     4 else: pc1<=pc1+4, v1<=1, buf_v<=0.
//   if22id_bus = v1 ? {pc1, buf_v ? buf_inst : inst_sram_rdata} : 64'b0 (comb).
//   Latency: addr issued edge N -> word on bus in cycle N+1; first fetch at RESET_PC
//     appears the first cycle after the first edge with rst_n=1 and no stall.
//   Hold rule: while stall[1]=1 the bus is stable for all stall cycles (first cycle
//     from SRAM, later cycles from buf_inst); SRAM output not relied on after 1 cycle.
//   No instruction lost/duplicated across any stall pattern: each pc appears on bus
//     with v1=1 in exactly one non-stall[1] cycle unless flushed by br_e.
//   br_e simultaneous with any stall: redirect wins; stall controller guarantees the
//     ID register is cleared on br_e, so flushed IF2 content is never consumed.
//   Back-to-back br_e: each redirect overrides the previous; only last target fetched.
//   stall[1]=1 with stall[0]=0 is illegal (controller never drives it); treat as rule 2.
//   Reset mid-operation: state cleared immediately; restart from RESET_PC.
// TESTING
//   Reset release, no stall -> bus {8000_0000,I0},{8000_0004,I1},{8000_0008,I2}.
//   stall[1:0]=11 for 3 cycles at pc 8000_0008, SRAM rdata garbage after cycle 1 ->
//     bus held {8000_0008,I2} all 3 cycles; then {8000_000C,I3}, no dup/skip.
//   stall[1:0]=01 one cycle at pc 8000_0004 -> {8000_0004,I1}, then 0, then {8000_0008,I2}.
//   br_e=1 br_addr=8000_0103 while stall=11 -> sram addr 8000_0100, next bus
//     {8000_0100,Ix}; buffered word discarded.
//   br_e=1 br_addr=FFFF_FFFC -> bus {FFFF_FFFC,..} then {0000_0000,..} (wrap).
//   rst_n low mid-stream with buf_v=1 -> bus 0 immediately; restart at 8000_0000.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch front end: IF1 computes the next PC and issues a synchronous
// instruction SRAM read; IF2 pairs the returned word with its PC for the ID stage.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned STALL_WD = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [STALL_WD-1:0] stall,
  input  logic                br_e,
  input  logic [31:0]         br_addr,
  output logic                inst_sram_en,
  output logic [31:0]         inst_sram_addr,
  input  logic [31:0]         inst_sram_rdata,
  output logic [63:0]         if22id_bus
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
  localparam logic [XLEN-1:0] PC_INIT = XLEN'(RESET_PC - PC_STEP);

  // pc1/v1: PC currently held in IF2 and whether it carries a live instruction.
  // buf_inst/buf_v: copy of the SRAM word captured on the first IF2-hold cycle,
  // since the SRAM output is only valid for one cycle after a read.
  logic [XLEN-1:0] pc1;
  logic            v1;
  logic [XLEN-1:0] buf_inst;
  logic            buf_v;

  logic [XLEN-1:0] seq_pc;
  logic [XLEN-1:0] next_pc;
  logic            hold_if1;
  logic            hold_if2;

  // Only stall[1:0] and the word-aligned part of br_addr matter to this stage.
  logic            unused_inputs;
  assign unused_inputs = ^{stall[STALL_WD-1:2], br_addr[1:0]};

  assign hold_if1 = stall[0];
  assign hold_if2 = stall[1];

  // Next fetch address: redirect target (word aligned) or sequential, wrapping at 2^32.
  always_comb begin
    seq_pc  = pc1 + PC_STEP;
    next_pc = seq_pc;
    if (br_e) begin
      next_pc = {br_addr[XLEN-1:2], 2'b00};
    end
  end

  // SRAM request: a redirect always fetches; otherwise fetch only when nothing stalls.
  always_comb begin
    inst_sram_en   = rst_n & (br_e | (!hold_if1 & !hold_if2));
    inst_sram_addr = next_pc;
  end

  // IF2 output: buffered word while held past the first stall cycle, else live SRAM data.
  always_comb begin
    if22id_bus = 64'h0;
    if (v1) begin
      if22id_bus = {pc1, (buf_v ? buf_inst : inst_sram_rdata)};
    end
  end

  // PC / valid / hold-buffer update; redirect beats IF2 hold beats IF1 hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc1      <= PC_INIT;
      v1       <= 1'b0;
      buf_inst <= '0;
      buf_v    <= 1'b0;
    end else if (br_e) begin
      pc1   <= next_pc;
      v1    <= 1'b1;
      buf_v <= 1'b0;
    end else if (hold_if2) begin
      if (v1 && !buf_v) begin
        buf_inst <= inst_sram_rdata;
        buf_v    <= 1'b1;
      end
    end else if (hold_if1) begin
      v1    <= 1'b0;
      buf_v <= 1'b0;
    end else begin
      pc1   <= seq_pc;
      v1    <= 1'b1;
      buf_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: SRAM model plus a program-order reference model in which
// the instruction at any PC is a fixed function of that PC.
module tb_if_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  stall;
  logic        br_e;
  logic [31:0] br_addr;
  logic        inst_sram_en;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_rdata;
  logic [63:0] if22id_bus;

  int checks = 0;
  int passed = 0;

  // Reference: PC of the instruction currently offered to ID, and whether one is offered.
  logic [31:0] m_pc;
  logic        m_v;

  if_fetch #(.RESET_PC(RESET_PC), .STALL_WD(6)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .br_e            (br_e),
    .br_addr         (br_addr),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_rdata (inst_sram_rdata),
    .if22id_bus      (if22id_bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Synchronous SRAM: data the cycle after a read; garbage when not read.
  always @(posedge clk) begin
    if (inst_sram_en) inst_sram_rdata <= word_at(inst_sram_addr);
    else              inst_sram_rdata <= $urandom;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_pc(input string tag, input logic [31:0] exp_pc);
    check(tag, {32'h0, if22id_bus[63:32]}, {32'h0, exp_pc});
  endtask

  task automatic model_reset();
    m_pc = RESET_PC - 32'd4;
    m_v  = 1'b0;
  endtask

  // One cycle: drive inputs just after a falling edge, check outputs, advance the model.
  task automatic step(input logic [5:0] s, input logic b, input logic [31:0] a);
    logic [31:0] tgt;
    logic        e_en;
    stall   = s;
    br_e    = b;
    br_addr = a;
    #1;
    tgt  = {a[31:2], 2'b00};
    e_en = b | (s[1:0] == 2'b00);
    check("bus", if22id_bus, m_v ? {m_pc, word_at(m_pc)} : 64'h0);
    check("sram_en", {63'h0, inst_sram_en}, {63'h0, e_en});
    if (e_en) check("sram_addr", {32'h0, inst_sram_addr}, {32'h0, (b ? tgt : m_pc + 32'd4)});
    @(posedge clk);
    if (b) begin
      m_pc = tgt;
      m_v  = 1'b1;
    end else if (s[1]) begin
      m_v = m_v;
    end else if (s[0]) begin
      m_v = 1'b0;
    end else begin
      m_pc = m_pc + 32'd4;
      m_v  = 1'b1;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [5:0]  rs;
    logic        rb;
    logic [31:0] ra;
    int          r;

    rst_n   = 1'b0;
    stall   = 6'h0;
    br_e    = 1'b0;
    br_addr = 32'h0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check("rst_bus", if22id_bus, 64'h0);
    check("rst_en", {63'h0, inst_sram_en}, 64'h0);
    rst_n = 1'b1;

    // Reset release, free-running fetch.
    step(6'h00, 1'b0, 32'h0);
    check_pc("first_pc", 32'h8000_0000);
    step(6'h00, 1'b0, 32'h0);
    check_pc("second_pc", 32'h8000_0004);

    // IF1-only stall for one cycle: bubble, then continue.
    step(6'h01, 1'b0, 32'h0);
    check("bubble", if22id_bus, 64'h0);
    step(6'h00, 1'b0, 32'h0);
    check_pc("after_bubble", 32'h8000_0008);

    // Full stall for three cycles with garbage SRAM data after the first.
    step(6'h03, 1'b0, 32'h0);
    step(6'h03, 1'b0, 32'h0);
    step(6'h03, 1'b0, 32'h0);
    check("held_word", if22id_bus, {32'h8000_0008, word_at(32'h8000_0008)});
    step(6'h00, 1'b0, 32'h0);
    check_pc("after_hold", 32'h8000_000C);

    // Redirect during full stall drops the buffered word.
    step(6'h03, 1'b0, 32'h0);
    step(6'h03, 1'b0, 32'h0);
    step(6'h03, 1'b1, 32'h8000_0103);
    check("redirect", if22id_bus, {32'h8000_0100, word_at(32'h8000_0100)});
    step(6'h00, 1'b0, 32'h0);

    // Redirect to the top word, then wrap to zero.
    step(6'h00, 1'b1, 32'hFFFF_FFFC);
    check_pc("top_pc", 32'hFFFF_FFFC);
    step(6'h00, 1'b0, 32'h0);
    check_pc("wrap_pc", 32'h0000_0000);

    // Back-to-back redirects: the last one wins.
    step(6'h00, 1'b1, 32'h0000_1000);
    step(6'h01, 1'b1, 32'h0000_2002);
    check_pc("b2b_pc", 32'h0000_2000);
    step(6'h00, 1'b0, 32'h0);

    // Randomised legal stall/redirect traffic.
    for (int i = 0; i < 400; i++) begin
      r  = $urandom_range(0, 2);
      rs = 6'($urandom) & 6'h3C;
      rs[1:0] = (r == 0) ? 2'b00 : ((r == 1) ? 2'b01 : 2'b11);
      rb = ($urandom_range(0, 7) == 0);
      ra = $urandom;
      step(rs, rb, ra);
    end

    // Reset asserted mid-stream while a word is buffered.
    step(6'h00, 1'b1, 32'h0000_4000);
    step(6'h03, 1'b0, 32'h0);
    step(6'h03, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("midrst_bus", if22id_bus, 64'h0);
    check("midrst_en", {63'h0, inst_sram_en}, 64'h0);
    model_reset();
    stall = 6'h00;
    br_e  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(6'h00, 1'b0, 32'h0);
    check_pc("restart_pc", 32'h8000_0000);
    step(6'h00, 1'b0, 32'h0);
    step(6'h00, 1'b0, 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
